// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: register fields and qualifiers in,
// stall/flush/forward controls and statistics out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int STAT_W = 16
);
  logic [REG_AW-1:0] i_src1_d;
  logic [REG_AW-1:0] i_src2_d;
  logic              i_use1_d;
  logic              i_use2_d;
  logic              i_branch_d;
  logic [REG_AW-1:0] i_src1_e;
  logic [REG_AW-1:0] i_src2_e;
  logic              i_use1_e;
  logic              i_use2_e;
  logic [REG_AW-1:0] i_rd_e;
  logic              i_reg_write_e;
  logic              i_mem_read_e;
  logic              i_flag_write_e;
  logic              i_branch_taken_e;
  logic [REG_AW-1:0] i_rd_w;
  logic              i_reg_write_w;

  logic              o_stall_pc;
  logic              o_stall_f;
  logic              o_stall_d;
  logic              o_stall_e;
  logic              o_flush_f;
  logic              o_flush_d;
  logic              o_flush_e;
  logic [1:0]        o_forward_a;
  logic [1:0]        o_forward_b;
  logic              o_fwd_dec_a;
  logic              o_fwd_dec_b;
  logic              o_alu_en;
  logic              o_busy;
  logic [STAT_W-1:0] o_stall_cnt;
  logic [STAT_W-1:0] o_flush_cnt;

  modport master (
    output i_src1_d, i_src2_d, i_use1_d, i_use2_d, i_branch_d,
    output i_src1_e, i_src2_e, i_use1_e, i_use2_e, i_rd_e,
    output i_reg_write_e, i_mem_read_e, i_flag_write_e, i_branch_taken_e,
    output i_rd_w, i_reg_write_w,
    input  o_stall_pc, o_stall_f, o_stall_d, o_stall_e,
    input  o_flush_f, o_flush_d, o_flush_e,
    input  o_forward_a, o_forward_b, o_fwd_dec_a, o_fwd_dec_b,
    input  o_alu_en, o_busy, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_src1_d, i_src2_d, i_use1_d, i_use2_d, i_branch_d,
    input  i_src1_e, i_src2_e, i_use1_e, i_use2_e, i_rd_e,
    input  i_reg_write_e, i_mem_read_e, i_flag_write_e, i_branch_taken_e,
    input  i_rd_w, i_reg_write_w,
    output o_stall_pc, o_stall_f, o_stall_d, o_stall_e,
    output o_flush_f, o_flush_d, o_flush_e,
    output o_forward_a, o_forward_b, o_fwd_dec_a, o_fwd_dec_b,
    output o_alu_en, o_busy, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the F/D/E/W MINI-RISC pipeline: W->E/W->D forwarding, load-use and
// flag stalls, multi-cycle taken-branch flushes, and saturating stall/flush statistics.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 3,
  parameter int LOAD_LAT   = 1,
  parameter int BR_FLUSH   = 2,
  parameter int R0_IS_ZERO = 0,
  parameter int STAT_W     = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int MAX_CNT = (LOAD_LAT > BR_FLUSH) ? LOAD_LAT : BR_FLUSH;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LD_STALL = 2'd1,
    S_BR_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_flush_d_prev;
  logic [STAT_W-1:0] r_stall_cnt;
  logic [STAT_W-1:0] r_flush_cnt;

  logic [REG_AW-1:0] w_src_e [2];
  logic [REG_AW-1:0] w_src_d [2];
  logic              w_use_e [2];
  logic              w_use_d [2];
  logic              w_fwd_e [2];
  logic              w_fwd_d [2];
  logic              w_lu_op [2];
  logic              w_lu;
  logic              w_fh;
  logic              w_taken;
  logic              w_stall;
  logic              w_flush;

  // A hard-wired r0 never carries a real value, so it must neither forward nor stall.
  function automatic logic match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && !((R0_IS_ZERO != 0) && (a == '0));
  endfunction

  assign w_src_e[0] = bus.i_src1_e;
  assign w_src_e[1] = bus.i_src2_e;
  assign w_src_d[0] = bus.i_src1_d;
  assign w_src_d[1] = bus.i_src2_d;
  assign w_use_e[0] = bus.i_use1_e;
  assign w_use_e[1] = bus.i_use2_e;
  assign w_use_d[0] = bus.i_use1_d;
  assign w_use_d[1] = bus.i_use2_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    assign w_fwd_e[gi] = bus.i_reg_write_w & w_use_e[gi] & match(bus.i_rd_w, w_src_e[gi]);
    assign w_fwd_d[gi] = bus.i_reg_write_w & w_use_d[gi] & match(bus.i_rd_w, w_src_d[gi]);
    assign w_lu_op[gi] = w_use_d[gi] & match(bus.i_rd_e, w_src_d[gi]);
  end

  assign w_lu    = bus.i_mem_read_e & bus.i_reg_write_e & (w_lu_op[0] | w_lu_op[1]);
  assign w_fh    = bus.i_branch_d & bus.i_flag_write_e;
  assign w_taken = bus.i_branch_taken_e;

  // A taken branch always wins; an in-progress flush ignores stall requests entirely.
  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_taken)            w_flush = 1'b1;
        else if (w_lu || w_fh)  w_stall = 1'b1;
      end
      S_LD_STALL: begin
        if (w_taken) w_flush = 1'b1;
        else         w_stall = 1'b1;
      end
      S_BR_FLUSH: w_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_flush_d_prev <= 1'b0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
    end else begin
      r_flush_d_prev <= w_stall | w_flush;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_taken) begin
            if (BR_FLUSH > 1) begin
              r_state <= S_BR_FLUSH;
              r_cnt   <= CW'(BR_FLUSH - 1);
            end
          end else if (w_lu && (LOAD_LAT > 1)) begin
            r_state <= S_LD_STALL;
            r_cnt   <= CW'(LOAD_LAT - 1);
          end
        end
        S_LD_STALL: begin
          if (w_taken) begin
            if (BR_FLUSH > 1) begin
              r_state <= S_BR_FLUSH;
              r_cnt   <= CW'(BR_FLUSH - 1);
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= S_IDLE;
          end
        end
        S_BR_FLUSH: begin
          if (w_taken) begin
            r_cnt <= CW'(BR_FLUSH - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every control output is gated by rst_n so it drops the moment reset is asserted.
  assign bus.o_stall_pc  = rst_n & w_stall;
  assign bus.o_stall_f   = rst_n & w_stall;
  assign bus.o_stall_d   = 1'b0;
  assign bus.o_stall_e   = 1'b0;
  assign bus.o_flush_f   = rst_n & w_flush;
  assign bus.o_flush_d   = rst_n & (w_stall | w_flush);
  assign bus.o_flush_e   = 1'b0;
  assign bus.o_forward_a = {rst_n & w_fwd_e[0], 1'b0};
  assign bus.o_forward_b = {rst_n & w_fwd_e[1], 1'b0};
  assign bus.o_fwd_dec_a = rst_n & w_fwd_d[0];
  assign bus.o_fwd_dec_b = rst_n & w_fwd_d[1];
  assign bus.o_alu_en    = rst_n & ~r_flush_d_prev;
  assign bus.o_busy      = rst_n & (r_state != S_IDLE);
  assign bus.o_stall_cnt = r_stall_cnt;
  assign bus.o_flush_cnt = r_flush_cnt;
endmodule
